// File: rtl/hy_riscv_pkg.sv
// hy_riscv_pkg: shared width defaults and ABI register indices for the Hanyang core.
package hy_riscv_pkg;
    localparam int XLEN_DEFAULT = 32;
    typedef logic [4:0] reg_idx_t;
    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_RA = 5'd1;
    localparam reg_idx_t REG_SP = 5'd2;
    localparam reg_idx_t REG_GP = 5'd3;
    localparam reg_idx_t REG_TP = 5'd4;
    localparam reg_idx_t REG_A0 = 5'd10;
    localparam reg_idx_t REG_A1 = 5'd11;
    localparam reg_idx_t REG_A2 = 5'd12;
    localparam reg_idx_t REG_A3 = 5'd13;
    localparam reg_idx_t REG_A4 = 5'd14;
    localparam reg_idx_t REG_A5 = 5'd15;
    localparam reg_idx_t REG_A6 = 5'd16;
    localparam reg_idx_t REG_A7 = 5'd17;
endpackage

// File: rtl/hy_riscv_regfile_if.sv
// hy_riscv_regfile_if: decode read ports, writeback write port and issue/scoreboard signals.
interface hy_riscv_regfile_if import hy_riscv_pkg::*; #(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int AW = 5
);
    logic [AW-1:0] rs1_addr;
    logic [AW-1:0] rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic we;
    logic [AW-1:0] rd_addr;
    logic [XLEN-1:0] rd_data;
    logic issue_valid;
    logic [AW-1:0] issue_rd;
    logic flush;
    logic rs1_busy;
    logic rs2_busy;
    modport master (
        output rs1_addr, rs2_addr, we, rd_addr, rd_data, issue_valid, issue_rd, flush,
        input rs1_data, rs2_data, rs1_busy, rs2_busy
    );
    modport slave (
        input rs1_addr, rs2_addr, we, rd_addr, rd_data, issue_valid, issue_rd, flush,
        output rs1_data, rs2_data, rs1_busy, rs2_busy
    );
endinterface

// File: rtl/hy_riscv_scoreboard.sv
// hy_riscv_scoreboard: per-register pending-write bits and source busy lookup for issue.
module hy_riscv_scoreboard import hy_riscv_pkg::*; #(
    parameter int NREGS = 32,
    parameter int AW = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    input  logic          we,
    input  logic [AW-1:0] rd_addr,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    input  logic          flush,
    output logic          rs1_busy,
    output logic          rs2_busy
);
    logic [NREGS-1:1] pend_q;
    logic [NREGS-1:1] pend_d;
    logic [NREGS-1:0] pend_all;
    // A new issue outranks a same-cycle writeback: the younger writer is still in flight.
    always_comb begin
        pend_d = pend_q;
        for (int i = 1; i < NREGS; i++)
            pend_d[i] = flush ? 1'b0 :
                        (issue_valid && issue_rd == AW'(i)) ? 1'b1 :
                        (we && rd_addr == AW'(i)) ? 1'b0 : pend_q[i];
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) pend_q <= '0;
        else pend_q <= pend_d;
    assign pend_all = {pend_q, 1'b0};
    assign rs1_busy = pend_all[rs1_addr] && rs1_addr != '0 && !(we && rd_addr == rs1_addr);
    assign rs2_busy = pend_all[rs2_addr] && rs2_addr != '0 && !(we && rd_addr == rs2_addr);
endmodule

// File: rtl/hy_riscv_regfile.sv
// hy_riscv_regfile: 2R/1W integer register file with x0 hardwired, write bypass and optional read register.
module hy_riscv_regfile import hy_riscv_pkg::*; #(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREGS = 32,
    parameter int REG_READ = 0
) (
    input logic clk,
    input logic reset_n,
    hy_riscv_regfile_if.slave rf
);
    localparam int AW = $clog2(NREGS);
    if (NREGS != 16 && NREGS != 32) begin : g_bad_nregs
        $error("hy_riscv_regfile: NREGS must be 16 or 32");
    end
    if ($bits(rf.rs1_addr) != AW || $bits(rf.rd_data) != XLEN) begin : g_bad_if
        $error("hy_riscv_regfile: interface widths do not match XLEN/NREGS");
    end
    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [XLEN-1:0] regs_d [1:NREGS-1];
    logic [XLEN-1:0] view [NREGS];
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    always_comb begin
        regs_d = regs_q;
        if (rf.we && rf.rd_addr != '0) regs_d[rf.rd_addr] = rf.rd_data;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) regs_q <= '{default: '0};
        else regs_q <= regs_d;
    // x0 has no storage; the read view supplies a constant zero in its slot.
    always_comb begin
        view[0] = '0;
        for (int i = 1; i < NREGS; i++) view[i] = regs_q[i];
    end
    assign rs1_val = rf.rs1_addr == '0 ? '0 :
                     (rf.we && rf.rd_addr == rf.rs1_addr) ? rf.rd_data : view[rf.rs1_addr];
    assign rs2_val = rf.rs2_addr == '0 ? '0 :
                     (rf.we && rf.rd_addr == rf.rs2_addr) ? rf.rd_data : view[rf.rs2_addr];
    if (REG_READ != 0) begin : g_reg_read
        logic [XLEN-1:0] rs1_data_q, rs1_data_d;
        logic [XLEN-1:0] rs2_data_q, rs2_data_d;
        always_comb begin
            rs1_data_d = rs1_val;
            rs2_data_d = rs2_val;
        end
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
                rs1_data_q <= '0;
                rs2_data_q <= '0;
            end else begin
                rs1_data_q <= rs1_data_d;
                rs2_data_q <= rs2_data_d;
            end
        assign rf.rs1_data = rs1_data_q;
        assign rf.rs2_data = rs2_data_q;
    end else begin : g_comb_read
        assign rf.rs1_data = rs1_val;
        assign rf.rs2_data = rs2_val;
    end
    hy_riscv_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
        .clk         (clk),
        .reset_n     (reset_n),
        .rs1_addr    (rf.rs1_addr),
        .rs2_addr    (rf.rs2_addr),
        .we          (rf.we),
        .rd_addr     (rf.rd_addr),
        .issue_valid (rf.issue_valid),
        .issue_rd    (rf.issue_rd),
        .flush       (rf.flush),
        .rs1_busy    (rf.rs1_busy),
        .rs2_busy    (rf.rs2_busy)
    );
endmodule

// File: tb/tb_hy_riscv_regfile.sv
// tb_hy_riscv_regfile: directed vectors into three configurations, expectations queued and checked by a monitor.
module tb_hy_riscv_regfile;
    import hy_riscv_pkg::*;
    logic clk = 0;
    logic reset_n = 0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    hy_riscv_regfile_if #(.XLEN(32), .AW(5)) if0 ();
    hy_riscv_regfile_if #(.XLEN(32), .AW(5)) if1 ();
    hy_riscv_regfile_if #(.XLEN(32), .AW(4)) if2 ();
    hy_riscv_regfile #(.XLEN(32), .NREGS(32), .REG_READ(0)) d0 (.clk(clk), .reset_n(reset_n), .rf(if0));
    hy_riscv_regfile #(.XLEN(32), .NREGS(32), .REG_READ(1)) d1 (.clk(clk), .reset_n(reset_n), .rf(if1));
    hy_riscv_regfile #(.XLEN(32), .NREGS(16), .REG_READ(0)) d2 (.clk(clk), .reset_n(reset_n), .rf(if2));
    typedef struct {
        int cyc;
        int dut;
        bit busy;
        logic [31:0] e1;
        logic [31:0] e2;
        string name;
    } exp_t;
    exp_t q[$];
    task automatic push(input int c, input int d, input bit b, input logic [31:0] e1, input logic [31:0] e2, input string nm);
        exp_t e;
        e.cyc = c; e.dut = d; e.busy = b; e.e1 = e1; e.e2 = e2; e.name = nm;
        q.push_back(e);
    endtask
    function automatic logic [63:0] actual(input int d, input bit b);
        case (d)
            0: actual = b ? {31'b0, if0.rs1_busy, 31'b0, if0.rs2_busy} : {if0.rs1_data, if0.rs2_data};
            1: actual = b ? {31'b0, if1.rs1_busy, 31'b0, if1.rs2_busy} : {if1.rs1_data, if1.rs2_data};
            default: actual = b ? {31'b0, if2.rs1_busy, 31'b0, if2.rs2_busy} : {if2.rs1_data, if2.rs2_data};
        endcase
    endfunction
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                logic [63:0] a;
                a = actual(q[i].dut, q[i].busy);
                checks++;
                if (q[i].cyc != cyc || a !== {q[i].e1, q[i].e2}) begin
                    errors++;
                    $display("FAIL %s dut%0d %s: got %h/%h want %h/%h", q[i].name, q[i].dut,
                             q[i].busy ? "busy" : "data", a[63:32], a[31:0], q[i].e1, q[i].e2);
                end
                q.delete(i);
            end
        end
    end
    task automatic idle16();
        if2.we = 0; if2.rd_addr = 0; if2.rd_data = 0; if2.rs1_addr = 0; if2.rs2_addr = 0;
        if2.issue_valid = 0; if2.issue_rd = 0; if2.flush = 0;
    endtask
    task automatic step(input logic w, input logic [4:0] rd, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input logic iv, input logic [4:0] ird, input logic fl,
                        input logic [31:0] e1, input logic [31:0] e2,
                        input logic b1, input logic b2, input string nm);
        @(posedge clk); #1;
        if0.we = w; if0.rd_addr = rd; if0.rd_data = wd; if0.rs1_addr = a1; if0.rs2_addr = a2;
        if0.issue_valid = iv; if0.issue_rd = ird; if0.flush = fl;
        if1.we = w; if1.rd_addr = rd; if1.rd_data = wd; if1.rs1_addr = a1; if1.rs2_addr = a2;
        if1.issue_valid = iv; if1.issue_rd = ird; if1.flush = fl;
        push(cyc, 0, 0, e1, e2, nm);
        push(cyc + 1, 1, 0, e1, e2, nm);
        push(cyc, 0, 1, {31'b0, b1}, {31'b0, b2}, nm);
        push(cyc, 1, 1, {31'b0, b1}, {31'b0, b2}, nm);
    endtask
    task automatic step16(input logic w, input logic [3:0] rd, input logic [31:0] wd,
                          input logic [3:0] a1, input logic [3:0] a2,
                          input logic [31:0] e1, input logic [31:0] e2, input string nm);
        @(posedge clk); #1;
        if0.we = 0; if0.issue_valid = 0; if0.flush = 0;
        if1.we = 0; if1.issue_valid = 0; if1.flush = 0;
        if2.we = w; if2.rd_addr = rd; if2.rd_data = wd; if2.rs1_addr = a1; if2.rs2_addr = a2;
        push(cyc, 2, 0, e1, e2, nm);
        push(cyc, 2, 1, 32'd0, 32'd0, nm);
    endtask
    initial begin
        if0.we = 0; if0.rd_addr = 0; if0.rd_data = 0; if0.rs1_addr = 5'd5; if0.rs2_addr = 5'd9;
        if0.issue_valid = 0; if0.issue_rd = 0; if0.flush = 0;
        if1.we = 0; if1.rd_addr = 0; if1.rd_data = 0; if1.rs1_addr = 5'd5; if1.rs2_addr = 5'd9;
        if1.issue_valid = 0; if1.issue_rd = 0; if1.flush = 0;
        idle16();
        if2.rs1_addr = 4'd3; if2.rs2_addr = 4'd15;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            push(cyc, d, 0, 32'd0, 32'd0, "reset");
            push(cyc, d, 1, 32'd0, 32'd0, "reset");
        end
        @(posedge clk); #1;
        reset_n = 1;
        for (int i = 0; i < 32; i++)
            step(0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0, 32'd0, 32'd0, 0, 0, "read_after_reset");
        step(1, REG_ZERO, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'd0, 32'd0, 0, 0, "write_x0_bypass");
        step(1, 5'd5, 32'h12345678, 0, 5'd1, 0, 0, 0, 32'd0, 32'd0, 0, 0, "write_x5");
        step(0, 0, 0, 5'd5, 5'd5, 0, 0, 0, 32'h12345678, 32'h12345678, 0, 0, "read_x5");
        step(1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 0, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, "bypass_x7");
        step(0, 0, 0, 5'd7, 5'd5, 0, 0, 0, 32'hA5A5A5A5, 32'h12345678, 0, 0, "stored_x7_x5");
        step(0, 0, 0, 0, 5'd3, 1, REG_GP, 0, 32'd0, 32'd0, 0, 0, "issue_x3");
        step(0, 0, 0, 0, 5'd3, 0, 0, 0, 32'd0, 32'd0, 0, 1, "busy_x3");
        step(1, 5'd3, 32'h33, 5'd3, 5'd3, 0, 0, 0, 32'h33, 32'h33, 0, 0, "wb_x3_unbusy");
        step(0, 0, 0, 5'd3, 5'd3, 0, 0, 0, 32'h33, 32'h33, 0, 0, "x3_cleared");
        step(0, 0, 0, 5'd3, 5'd3, 1, 5'd3, 0, 32'h33, 32'h33, 0, 0, "reissue_x3");
        step(1, 5'd3, 32'h44, 5'd3, 5'd3, 1, 5'd3, 0, 32'h44, 32'h44, 0, 0, "issue_and_wb_x3");
        step(0, 0, 0, 5'd3, 5'd3, 0, 0, 0, 32'h44, 32'h44, 1, 1, "x3_still_pending");
        step(1, 5'd3, 32'h55, 5'd3, 5'd3, 0, 0, 0, 32'h55, 32'h55, 0, 0, "wb_x3_again");
        step(0, 0, 0, 5'd4, 5'd9, 1, REG_TP, 0, 32'd0, 32'd0, 0, 0, "issue_x4");
        step(0, 0, 0, 5'd4, 5'd9, 1, 5'd9, 0, 32'd0, 32'd0, 1, 0, "issue_x9");
        step(1, 5'd9, 32'h99, 5'd4, 5'd9, 1, REG_A0, 1, 32'd0, 32'h99, 1, 0, "flush_cycle");
        step(0, 0, 0, 5'd4, REG_A0, 0, 0, 0, 32'd0, 32'd0, 0, 0, "after_flush_x4_x10");
        step(0, 0, 0, 5'd9, 5'd5, 0, 0, 0, 32'h99, 32'h12345678, 0, 0, "after_flush_x9");
        step(0, 0, 0, REG_A0, 5'd7, 0, 0, 0, 32'd0, 32'hA5A5A5A5, 0, 0, "after_flush_x10");
        step16(1, 4'd15, 32'h0000FFFF, 4'd15, 4'd0, 32'h0000FFFF, 32'd0, "rv32e_write_x15");
        step16(0, 4'd0, 32'd0, 4'd15, 4'd15, 32'h0000FFFF, 32'h0000FFFF, "rv32e_read_x15");
        step16(1, 4'd0, 32'hDEADBEEF, 4'd0, 4'd15, 32'd0, 32'h0000FFFF, "rv32e_write_x0");
        repeat (3) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            errors += q.size();
            $display("FAIL pending_expectations: got %0d unchecked want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
